// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the controller-side request/response signals and the external
// req/ack byte-memory bus of mem_access_unit.
//   Controller side : ifetch_req, mem_read, mem_write, pc_addr, data_addr,
//                     wdata -> ; <- instr_out, rdata_out, busy, done, err
//   Memory side     : ext_req, ext_we, ext_addr, ext_wdata -> ;
//                     <- ext_rdata, ext_ack
// The slave modport is the access unit's view of the bundle; the master
// modport is the view of whoever drives requests and models the memory.
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 16
);
  logic              ifetch_req;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] data_addr;
  logic [15:0]       wdata;
  logic [15:0]       instr_out;
  logic [15:0]       rdata_out;
  logic              busy;
  logic              done;
  logic              err;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [7:0]        ext_wdata;
  logic [7:0]        ext_rdata;
  logic              ext_ack;

  modport slave (
    input  ifetch_req, mem_read, mem_write, pc_addr, data_addr, wdata,
    input  ext_rdata, ext_ack,
    output instr_out, rdata_out, busy, done, err,
    output ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output ifetch_req, mem_read, mem_write, pc_addr, data_addr, wdata,
    output ext_rdata, ext_ack,
    input  instr_out, rdata_out, busy, done, err,
    input  ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-side responder for the multicycle controller. One 16-bit fetch,
// load or store at a time is carried out as two 8-bit beats (low byte at the
// base address, high byte at base+1) on a req/ack external byte memory.
// Completion is a one-cycle done pulse; err accompanies done when a beat
// waited TIMEOUT_CYC cycles without ext_ack.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - mem_access_unit_if.slave (controller requests/results and the
//          external byte-memory bus)
// All outputs are registered, so they change only on clock edges or reset.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  // A beat gives up in the cycle where the counter holds TIMEOUT_CYC-1 and
  // ack is still absent, i.e. after exactly TIMEOUT_CYC waiting cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q,     state_d;
  kind_t             kind_q,      kind_d;
  logic [ADDR_W-1:0] base_q,      base_d;
  logic [15:0]       wdata_q,     wdata_d;
  logic [7:0]        lo_q,        lo_d;
  logic [7:0]        cnt_q,       cnt_d;
  logic [15:0]       instr_q,     instr_d;
  logic [15:0]       rdata_q,     rdata_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              ext_req_q,   ext_req_d;
  logic              ext_we_q,    ext_we_d;
  logic [ADDR_W-1:0] ext_addr_q,  ext_addr_d;
  logic [7:0]        ext_wdata_q, ext_wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      base_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
    end
  end

  // Next-state logic. Output registers are loaded with the value they must
  // show in the state being entered, so ext_* are stable for a whole beat.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_write || bus.mem_read || bus.ifetch_req) begin
          // Fixed priority; losing requests are simply dropped.
          if (bus.mem_write) begin
            kind_d = K_STORE;
            base_d = bus.data_addr;
          end else if (bus.mem_read) begin
            kind_d = K_LOAD;
            base_d = bus.data_addr;
          end else begin
            kind_d = K_FETCH;
            base_d = bus.pc_addr;
          end
          wdata_d     = bus.wdata;
          state_d     = S_LO;
          cnt_d       = '0;
          busy_d      = 1'b1;
          ext_req_d   = 1'b1;
          ext_we_d    = bus.mem_write;
          ext_addr_d  = bus.mem_write || bus.mem_read ? bus.data_addr : bus.pc_addr;
          ext_wdata_d = bus.wdata[7:0];
        end
      end

      S_LO: begin
        if (bus.ext_ack) begin
          if (kind_q != K_STORE) begin
            lo_d = bus.ext_rdata;
          end
          // ext_req stays high; address and data switch to the high beat.
          state_d     = S_HI;
          cnt_d       = '0;
          ext_addr_d  = base_q + ADDR_W'(1);
          ext_wdata_d = wdata_q[15:8];
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_HI: begin
        if (bus.ext_ack) begin
          if (kind_q == K_FETCH) begin
            instr_d = {bus.ext_rdata, lo_q};
          end else if (kind_q == K_LOAD) begin
            rdata_d = {bus.ext_rdata, lo_q};
          end
          state_d   = S_FIN;
          done_d    = 1'b1;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_FIN: begin
        // Requests seen here are ignored; IDLE samples them next cycle.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        ext_req_d = 1'b0;
        ext_we_d  = 1'b0;
      end
    endcase
  end

  assign bus.instr_out = instr_q;
  assign bus.rdata_out = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int ADDR_W = 16;
  localparam int TO_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Byte memory model with a configurable number of wait cycles per beat.
  logic [7:0]  mem [0:65535];
  int          wait_n = 0;     // -1: never acknowledge
  int          wcnt = 0;
  int          beat_n = 0;
  logic [15:0] beat_addr [0:7];
  logic        beat_we   [0:7];

  always @(negedge clk) begin
    if (bus.ext_req && !rst) begin
      if (wait_n >= 0 && wcnt == wait_n) begin
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = mem[bus.ext_addr];
        if (bus.ext_we) mem[bus.ext_addr] = bus.ext_wdata;
        if (beat_n < 8) begin
          beat_addr[beat_n] = bus.ext_addr;
          beat_we[beat_n]   = bus.ext_we;
        end
        beat_n++;
        wcnt = 0;
      end else begin
        bus.ext_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.ext_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int got_cyc;
  logic got_err;
  logic post_busy, post_done;

  // Pulses one request in cycle 0 and counts cycles until done.
  task automatic run_access(input int kind, input logic [15:0] addr, input logic [15:0] wd,
                            input int wn, input bit with_fetch, input int wr_at);
    wait_n = wn;
    beat_n = 0;
    @(posedge clk); #1;
    case (kind)
      0: begin bus.ifetch_req = 1'b1; bus.pc_addr = addr; end
      1: begin bus.mem_read = 1'b1; bus.data_addr = addr; end
      default: begin bus.mem_write = 1'b1; bus.data_addr = addr; bus.wdata = wd; end
    endcase
    if (with_fetch) begin bus.ifetch_req = 1'b1; bus.pc_addr = 16'h0010; end
    got_cyc = -1;
    got_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.ifetch_req = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      if (c == wr_at) begin
        bus.mem_write = 1'b1; bus.data_addr = 16'h0400; bus.wdata = 16'h5555;
      end
      if (bus.done) begin
        got_cyc = c;
        got_err = bus.err;
        break;
      end
    end
    @(posedge clk); #1;
    bus.ifetch_req = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    post_busy = bus.busy;
    post_done = bus.done;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [15:0] addr;
    logic [15:0] wd;
    int          wn;
    bit          wf;     // also pulse ifetch_req with the request
    int          wr_at;  // cycle to pulse a stray mem_write, -1 none
    int          cyc;
    logic        err;
    logic [15:0] instr;
    logic [15:0] rdata;
    int          beats;
    logic [15:0] a0;
    logic [15:0] a1;
  } vec_t;

  vec_t tv [0:8];

  initial begin
    tv[0] = '{0, 16'h0010, 16'h0000,  0, 1'b0, -1, 3, 1'b0, 16'h1234, 16'h0000, 2, 16'h0010, 16'h0011};
    tv[1] = '{2, 16'h0200, 16'hBEEF,  2, 1'b0, -1, 7, 1'b0, 16'h1234, 16'h0000, 2, 16'h0200, 16'h0201};
    tv[2] = '{1, 16'h0200, 16'h0000,  0, 1'b0, -1, 3, 1'b0, 16'h1234, 16'hBEEF, 2, 16'h0200, 16'h0201};
    tv[3] = '{1, 16'h0020, 16'h0000,  0, 1'b1,  2, 3, 1'b0, 16'h1234, 16'h5678, 2, 16'h0020, 16'h0021};
    tv[4] = '{1, 16'hFFFF, 16'h0000,  1, 1'b0, -1, 5, 1'b0, 16'h1234, 16'hABCD, 2, 16'hFFFF, 16'h0000};
    tv[5] = '{1, 16'h0101, 16'h0000,  0, 1'b0, -1, 3, 1'b0, 16'h1234, 16'h2211, 2, 16'h0101, 16'h0102};
    tv[6] = '{0, 16'h0020, 16'h0000,  3, 1'b0, -1, 9, 1'b0, 16'h5678, 16'h2211, 2, 16'h0020, 16'h0021};
    tv[7] = '{0, 16'h0010, 16'h0000,  0, 1'b0,  3, 3, 1'b0, 16'h1234, 16'h2211, 2, 16'h0010, 16'h0011};
    tv[8] = '{1, 16'h0010, 16'h0000, -1, 1'b0, -1, 5, 1'b1, 16'h1234, 16'h2211, 0, 16'h0000, 16'h0000};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'h0020] = 8'h78; mem[16'h0021] = 8'h56;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;

    bus.ifetch_req = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.pc_addr = '0; bus.data_addr = '0; bus.wdata = '0;
    bus.ext_ack = 1'b0; bus.ext_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", 32'(bus.instr_out), 32'h0);
    chk("rst_rdata", 32'(bus.rdata_out), 32'h0);
    chk("rst_ctrl", {27'd0, bus.busy, bus.done, bus.err, bus.ext_req, bus.ext_we}, 32'h0);
    chk("rst_ext_addr", 32'(bus.ext_addr), 32'h0);
    rst = 1'b0;

    // Table-driven accesses
    for (int i = 0; i < 9; i++) begin
      run_access(tv[i].kind, tv[i].addr, tv[i].wd, tv[i].wn, tv[i].wf, tv[i].wr_at);
      if (got_cyc < 0) begin
        errors++; checks++;
        $display("FAIL v%0d_done_wait: no done within 40 cycles", i);
      end else begin
        chk($sformatf("v%0d_done_cyc", i), 32'(got_cyc), 32'(tv[i].cyc));
      end
      chk($sformatf("v%0d_err", i), 32'(got_err), 32'(tv[i].err));
      chk($sformatf("v%0d_instr", i), 32'(bus.instr_out), 32'(tv[i].instr));
      chk($sformatf("v%0d_rdata", i), 32'(bus.rdata_out), 32'(tv[i].rdata));
      chk($sformatf("v%0d_post", i), {30'd0, post_busy, post_done}, 32'h0);
      chk($sformatf("v%0d_beats", i), 32'(beat_n), 32'(tv[i].beats));
      if (tv[i].beats == 2 && beat_n == 2) begin
        chk($sformatf("v%0d_addr0", i), 32'(beat_addr[0]), 32'(tv[i].a0));
        chk($sformatf("v%0d_addr1", i), 32'(beat_addr[1]), 32'(tv[i].a1));
        chk($sformatf("v%0d_we", i), {30'd0, beat_we[0], beat_we[1]},
            (tv[i].kind == 2) ? 32'h3 : 32'h0);
      end
      if (tv[i].kind == 2) begin
        chk($sformatf("v%0d_mem_lo", i), 32'(mem[tv[i].addr]), 32'(tv[i].wd[7:0]));
        chk($sformatf("v%0d_mem_hi", i), 32'(mem[tv[i].addr + 16'd1]), 32'(tv[i].wd[15:8]));
      end
    end
    chk("stray_write_mem", 32'(mem[16'h0400]), 32'h0);

    // Reset asserted during the high beat of a store
    wait_n = 2;
    beat_n = 0;
    @(posedge clk); #1;
    bus.mem_write = 1'b1; bus.data_addr = 16'h0300; bus.wdata = 16'hA5A5;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hi_beat_addr", 32'(bus.ext_addr), 32'h0301);
    chk("hi_beat_we", {30'd0, bus.ext_req, bus.ext_we}, 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ext", {30'd0, bus.ext_req, bus.ext_we}, 32'h0);
    chk("mid_rst_outs", {bus.instr_out, bus.rdata_out}, 32'h0);
    chk("mid_rst_ctrl", {29'd0, bus.busy, bus.done, bus.err}, 32'h0);
    chk("mid_rst_addr", {8'd0, bus.ext_addr, bus.ext_wdata}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_mem_hi", 32'(mem[16'h0301]), 32'h0);

    run_access(0, 16'h0010, 16'h0000, 0, 1'b0, -1);
    chk("after_rst_cyc", 32'(got_cyc), 32'd3);
    chk("after_rst_instr", 32'(bus.instr_out), 32'h1234);
    chk("after_rst_rdata", 32'(bus.rdata_out), 32'h0);
    chk("after_rst_err", 32'(got_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
